// File: rtl/multiword_add_seq.sv
// Multi-word add/subtract sequencer: feeds wide operands through a 16-bit adder
// one slice per cycle (LSW first) and presents the result with carry and overflow.
module multiword_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  overflow
);
  localparam int unsigned W  = 16 * WORDS;
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    opa, opb;
  logic            carry;
  logic [KW-1:0]   k;
  logic [15:0]     slice_a, slice_b, slice_s;
  logic            slice_c;
  logic            last;
  logic            accept;

  assign slice_a = opa[16*k +: 16];
  assign slice_b = opb[16*k +: 16];
  assign {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {16'd0, carry};
  assign last   = (k == K_LAST);
  assign accept = in_valid && (state == IDLE);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the inverted operand and forced carry are captured up front.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa      <= '0;
      opb      <= '0;
      carry    <= 1'b0;
      k        <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      k     <= '0;
    end else if (state == RUN) begin
      sum[16*k +: 16] <= slice_s;
      carry           <= slice_c;
      if (last) begin
        k        <= '0;
        cout     <= slice_c;
        overflow <= (opa[W-1] == opb[W-1]) && (slice_s[15] != opa[W-1]);
      end else begin
        k <= k + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: directed vectors, random operands and
// reset scenarios on a 4-word and a 1-word instance against an arithmetic model.
module tb_multiword_add_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid4 = 0, in_ready4, cin4 = 0, sub4 = 0, out_valid4, out_ready4 = 0, cout4, ovf4;
  logic [63:0] a4 = '0, b4 = '0, sum4;
  logic        in_valid1 = 0, in_ready1, cin1 = 0, sub1 = 0, out_valid1, out_ready1 = 0, cout1, ovf1;
  logic [15:0] a1 = '0, b1 = '0, sum1;

  int ntests = 0;
  int nfail  = 0;

  multiword_add_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  multiword_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Signed/unsigned arithmetic on w-bit values: A+B+cin or A-B.
  task automatic model(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s,
                       input int w, output logic [63:0] sm, output logic co, output logic ov);
    logic [65:0] mask, ux, uy;
    logic signed [65:0] sx, sy, r;
    mask = (66'd1 << w) - 66'd1;
    ux = {2'b00, x} & mask;
    uy = {2'b00, y} & mask;
    sx = $signed(ux);
    sy = $signed(uy);
    if (ux[w-1]) sx = sx - $signed(66'd1 << w);
    if (uy[w-1]) sy = sy - $signed(66'd1 << w);
    if (s) begin
      r  = sx - sy;
      co = (ux >= uy);
    end else begin
      r  = sx + sy + $signed({65'd0, c});
      co = ((ux + uy + {65'd0, c}) > mask);
    end
    ov = (r > $signed(mask >> 1)) || (r < -$signed((mask >> 1) + 66'd1));
    sm = r[63:0] & mask[63:0];
  endtask

  function automatic logic [63:0] obs_sum(input bit sel);
    return sel ? {48'd0, sum1} : sum4;
  endfunction
  function automatic logic [2:0] obs_flags(input bit sel);
    return sel ? {in_ready1, cout1, ovf1} : {in_ready4, cout4, ovf4};
  endfunction
  function automatic logic obs_ov(input bit sel);
    return sel ? out_valid1 : out_valid4;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [63:0] ta, input logic [63:0] tb_,
                       input logic tc, input logic ts);
    if (sel) begin in_valid1 = v; a1 = ta[15:0]; b1 = tb_[15:0]; cin1 = tc; sub1 = ts; end
    else     begin in_valid4 = v; a4 = ta;       b4 = tb_;       cin4 = tc; sub4 = ts; end
  endtask

  task automatic set_ready(input bit sel, input logic v);
    if (sel) out_ready1 = v; else out_ready4 = v;
  endtask

  task automatic op(input bit sel, input logic [63:0] ta, input logic [63:0] tb_,
                    input logic tc, input logic ts, input int stall);
    logic [63:0] esum;
    logic        eco, eov;
    int          lat;
    int          w = sel ? 16 : 64;
    model(ta, tb_, tc, ts, w, esum, eco, eov);
    @(negedge clk);
    check("in_ready_before", {63'd0, obs_flags(sel)[2]}, 64'd1);
    drive(sel, 1'b1, ta, tb_, tc, ts);
    @(posedge clk);
    #1;
    // scramble inputs after accept; they must not matter
    drive(sel, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    lat = 0;
    while (!obs_ov(sel) && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), sel ? 64'd1 : 64'd4);
    check("sum", obs_sum(sel), esum);
    check("cout", {63'd0, obs_flags(sel)[1]}, {63'd0, eco});
    check("overflow", {63'd0, obs_flags(sel)[0]}, {63'd0, eov});
    for (int i = 0; i < stall; i++) begin
      drive(sel, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      check("stall_sum", obs_sum(sel), esum);
      check("stall_flags", {61'd0, obs_flags(sel)}, {61'd0, 1'b0, eco, eov});
      check("stall_valid", {63'd0, obs_ov(sel)}, 64'd1);
    end
    drive(sel, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    set_ready(sel, 1'b1);
    @(posedge clk);
    #1;
    set_ready(sel, 1'b0);
    check("after_hs_valid", {63'd0, obs_ov(sel)}, 64'd0);
    check("after_hs_ready", {63'd0, obs_flags(sel)[2]}, 64'd1);
    check("after_hs_sum", obs_sum(sel), esum);
  endtask

  initial begin
    #12;
    check("reset_state4", {sum4, 3'b0} >> 3, 64'd0);
    check("reset_flags4", {59'd0, in_ready4, out_valid4, cout4, ovf4, 1'b0}, {59'd0, 5'b10000});
    rst = 1'b0;

    op(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
    op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0);
    op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    op(0, 64'h5, 64'h7, 1'b1, 1'b1, 0);
    op(0, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 10);
    for (int i = 0; i < 20; i++)
      op(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // asynchronous reset mid-idle with a nonzero result on the outputs
    op(0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_idle_sum", sum4, 64'd0);
    check("rst_idle_flags", {60'd0, in_ready4, out_valid4, cout4, ovf4}, {60'd0, 4'b1000});
    @(negedge clk);
    rst = 1'b0;

    // reset two cycles into RUN: the operation must vanish
    @(negedge clk);
    drive(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_run_sum", sum4, 64'd0);
    check("rst_run_ready", {63'd0, in_ready4}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk);
        #1;
        if (out_valid4) seen++;
      end
      check("rst_run_no_result", 64'(seen), 64'd0);
    end
    op(0, 64'h1, 64'h2, 1'b0, 1'b0, 0);

    op(1, 64'hFFFF, 64'h1, 1'b0, 1'b0, 0);
    op(1, 64'h7FFF, 64'h1, 1'b0, 1'b0, 2);
    op(1, 64'h8000, 64'h1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++)
      op(1, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Multi-word add/subtract sequencer that sits directly around the team's 16-bit prefix adder. It accepts wide operands over a valid/ready handshake and feeds them to the 16-bit adder one 16-bit slice per cycle, LSW first. Each slice's carry-out becomes the next slice's carry-in. It assembles the wide result and presents it downstream with carry-out and signed overflow over a second valid/ready handshake.

## Interface
- WORDS, default 4: number of 16-bit slices. Operand width is W = 16*WORDS. Legal range is 1..16.
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set offered
- in_ready  out  1  block can accept operands
- a  in  W  operand A
- b  in  W  operand B
- cin  in  1  carry-in for add; ignored when sub=1
- sub  in  1  1 = compute A-B, 0 = compute A+B+cin
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- sum  out  W  result
- cout  out  1  carry out of bit W-1 (for sub: 1 = no borrow)
- overflow  out  1  two's-complement overflow of the W-bit result

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE, on in_valid&&in_ready:
  - Capture a into opa.
  - Capture b into opb; if sub=1, capture ~b instead.
  - Set carry reg = sub ? 1 : cin.
  - Clear slice index k to 0 and go to RUN.
- RUN, each cycle:
  - Slice k: {c,s} = opa[16k+15:16k] + opb[16k+15:16k] + carry.
  - Write s into sum[16k+15:16k]; carry <= c; k <= k+1.
- RUN, on the cycle with k = WORDS-1:
  - cout <= c.
  - overflow <= (opa[W-1] == opb[W-1]) && (s[15] != opa[W-1]), where opb is the possibly-inverted operand.
  - Go to DONE.
- DONE, on out_ready: go to IDLE. sum, cout and overflow keep their values until the next operation writes them.
- in_valid while in_ready=0 is ignored. Operands are not queued.
- a, b, cin, sub are sampled only on the accept edge. Changes afterwards have no effect.
- The slice adder is the team's 16-bit prefix adder, or a functionally identical 17-bit add. k is a ceil(log2(WORDS)) bit counter; for WORDS=1 it is a 1-bit counter held at 0.

## Timing
- Reset, asynchronous, any state, immediate:
  - State → IDLE, k=0, carry=0.
  - sum=0, cout=0, overflow=0, out_valid=0, in_ready=1.
  - An in-flight operation is discarded and no result is emitted.
- Latency: operands accepted at edge E0. Slices are written at edges E1..E_WORDS. out_valid is high after E_WORDS, i.e. WORDS cycles after accept.
- Throughput: result handshake at edge E_WORDS+m (m≥1). IDLE is entered on that same edge, and the next accept is possible at the following edge. Peak rate is one operation per WORDS+2 cycles.
- in_ready and out_valid are decoded from state registers only, with no combinational path from any input.
- Outputs are stable for the whole time out_valid=1, independent of out_ready stalls of any length.
- WORDS=1: RUN lasts one cycle; the overflow and cout rules still apply.
- Intermediate sum slices become visible while in RUN. Consumers qualify sum with out_valid.

## Test plan
- Reset: assert rst mid-idle → in_ready=1, out_valid=0, sum=0, cout=0, overflow=0 immediately, without a clock edge.
- WORDS=4, add: a=0x0000_0000_0000_FFFF, b=0x1, cin=0 → sum=0x0000_0000_0001_0000, cout=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge.
- Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1, overflow=0. Also a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0x8000_0000_0000_0000, overflow=1, cout=0.
- Subtract:
  - a=5, b=7, sub=1, cin=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0 (cin ignored).
  - a=0x8000_0000_0000_0000, b=1, sub=1 → sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulsing in_valid with new operands → sum/cout/overflow unchanged, in_ready=0 throughout, new operands not taken. After out_ready, the next accept happens one cycle later.
- Reset mid-RUN: assert rst 2 cycles after accept → out_valid never rises for that operation. A following operation a=1, b=2 gives sum=3 with correct 4-cycle latency. Repeat the add vector with WORDS=1.
